// File: rtl/dual_port_ram.sv
// dual_port_ram: single-clock word store with a read/write port A (write-first)
// and a read-only port B (read-first). Both read paths are registered; the
// synchronous reset clears only the two output registers and blocks writes,
// leaving the storage contents untouched.
module dual_port_ram #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 nRST,       // synchronous, active-high despite the name
    input  logic [ADDR_SIZE-1:0] addr_A,
    input  logic [DATA_SIZE-1:0] data_in_A,
    input  logic                 w_e_A,
    output logic [DATA_SIZE-1:0] data_out_A,
    input  logic [ADDR_SIZE-1:0] addr_B,
    output logic [DATA_SIZE-1:0] data_out_B
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    // Storage starts all-zero; the declaration initialiser also becomes the
    // FPGA power-up contents of the inferred block RAM.
    logic [DATA_SIZE-1:0] r_mem [0:DEPTH-1] = '{default: '0};

    // Output registers power up at zero so reads before the first edge are 0.
    logic [DATA_SIZE-1:0] r_data_out_A_reg = '0;
    logic [DATA_SIZE-1:0] r_data_out_B_reg = '0;

    // A write only happens outside reset.
    logic w_write_en;
    assign w_write_en = w_e_A && !nRST;

    // Storage write: kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_write_en) begin
            r_mem[addr_A] <= data_in_A;
        end
    end

    // Port A registered read, write-first: a write forwards its own data.
    always_ff @(posedge clk) begin
        if (nRST) begin
            r_data_out_A_reg <= '0;
        end else if (w_e_A) begin
            r_data_out_A_reg <= data_in_A;
        end else begin
            r_data_out_A_reg <= r_mem[addr_A];
        end
    end

    // Port B registered read, read-first: sees the pre-write contents when it
    // collides with a port A write in the same cycle.
    always_ff @(posedge clk) begin
        if (nRST) begin
            r_data_out_B_reg <= '0;
        end else begin
            r_data_out_B_reg <= r_mem[addr_B];
        end
    end

    assign data_out_A = r_data_out_A_reg;
    assign data_out_B = r_data_out_B_reg;

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: the stimulus process drives inputs on the
// falling edge and pushes the expected outputs computed from a sparse
// behavioural memory model; an independent monitor pops and compares after
// every rising edge.
module tb_dual_port_ram;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nRST = 1'b1;
    logic [AW-1:0] addr_A = '0;
    logic [DW-1:0] data_in_A = '0;
    logic          w_e_A = 1'b0;
    logic [DW-1:0] data_out_A;
    logic [AW-1:0] addr_B = '0;
    logic [DW-1:0] data_out_B;

    dual_port_ram #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .addr_A     (addr_A),
        .data_in_A  (data_in_A),
        .w_e_A      (w_e_A),
        .data_out_A (data_out_A),
        .addr_B     (addr_B),
        .data_out_B (data_out_B)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        int            id;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [bit [AW-1:0]];   // absent key == never written == 0
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_txn = 0;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return model.exists(a) ? model[a] : '0;
    endfunction

    // One transaction: drive on the falling edge, predict what the outputs must
    // hold after the coming rising edge, then update the model.
    task automatic drive(input logic rst, input logic we, input logic [AW-1:0] aa,
                         input logic [DW-1:0] din, input logic [AW-1:0] ab);
        exp_t e;
        @(negedge clk);
        nRST = rst; w_e_A = we; addr_A = aa; data_in_A = din; addr_B = ab;
        if (rst) begin
            e.exp_a = '0;
            e.exp_b = '0;
        end else begin
            e.exp_a = we ? din : model_rd(aa);
            e.exp_b = model_rd(ab);        // old contents even on a same-address write
            if (we) model[aa] = din;
        end
        e.id = n_txn;
        n_txn++;
        sb.push_back(e);
        $display("txn %0d: rst=%0b we=%0b addrA=%h din=%h addrB=%h -> expA=%h expB=%h",
                 e.id, rst, we, aa, din, ab, e.exp_a, e.exp_b);
    endtask

    // Monitor: outputs before the first edge, then one comparison pair per edge.
    initial begin
        #1;
        n_cmp++;
        if (data_out_A !== '0) begin n_err++; $display("FAIL init_A: got %h want 0", data_out_A); end
        n_cmp++;
        if (data_out_B !== '0) begin n_err++; $display("FAIL init_B: got %h want 0", data_out_B); end
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (data_out_A !== e.exp_a) begin
                    n_err++;
                    $display("FAIL txn%0d_out_A: got %h want %h", e.id, data_out_A, e.exp_a);
                end
                n_cmp++;
                if (data_out_B !== e.exp_b) begin
                    n_err++;
                    $display("FAIL txn%0d_out_B: got %h want %h", e.id, data_out_B, e.exp_b);
                end
            end
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return AW'($urandom_range(0, 15));
            1:       return AW'(16'hFFF0 + AW'($urandom_range(0, 15)));
            default: return AW'($urandom);
        endcase
    endfunction

    // Stimulus: directed test plan, then randomized traffic.
    initial begin
        int wait_cycles;
        // reset outputs
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // basic write/read
        drive(0, 1, 0, 245, 0);
        drive(0, 0, 0, 245, 0);
        // independent port B address; data_in ignored without write enable
        drive(0, 0, 0, 420, 1);
        drive(0, 0, 0, 420, 0);
        // same-address collision
        drive(0, 1, 5, 7, 5);
        drive(0, 1, 5, 9, 5);
        drive(0, 0, 5, 0, 5);
        // reset blocks write, memory preserved
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // address extremes
        drive(0, 1, 16'hFFFF, 32'hDEADBEEF, 0);
        drive(0, 1, 16'h0000, 32'h12345678, 16'hFFFF);
        drive(0, 0, 16'hFFFF, 0, 16'h0000);
        drive(0, 0, 16'h0000, 0, 16'hFFFF);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic          r_rst;
            logic          r_we;
            logic [AW-1:0] r_aa;
            logic [AW-1:0] r_ab;
            r_rst = ($urandom_range(0, 19) == 0);
            r_we  = $urandom_range(0, 1) == 1;
            r_aa  = rand_addr();
            r_ab  = ($urandom_range(0, 3) == 0) ? r_aa : rand_addr();
            drive(r_rst, r_we, r_aa, DW'($urandom), r_ab);
        end
        @(negedge clk);
        nRST = 1'b0; w_e_A = 1'b0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
